// File: rtl/controlador_interrupciones.sv
// Eight-level interrupt controller: edge-detected requests, mask, fixed priority
// (level 0 highest), in-service nesting and handler vector generation.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// REPOSO    | nothing presented; arbitrate eligible pending levels
// SOLICITUD | one level presented on interrupcion_o, waiting for ack or withdrawal
module controlador_interrupciones #(
    parameter int                  PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0] VEC_BASE   = 10'h3C0,
    parameter int                  VEC_STRIDE = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [7:0]          irq_i,
    input  logic                habilitar_i,
    input  logic                we_mask_i,
    input  logic [7:0]          dato_mask_i,
    input  logic                ack_i,
    input  logic                eoi_i,
    output logic [7:0]          interrupcion_o,
    output logic [PC_WIDTH-1:0] vector_o,
    output logic [7:0]          pendientes_o,
    output logic [7:0]          en_servicio_o
);

    typedef enum logic [0:0] {
        REPOSO    = 1'b0,
        SOLICITUD = 1'b1
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [7:0]          irq_prev_q;
    logic [7:0]          pend_q, pend_d;
    logic [7:0]          mask_q, mask_d;
    logic [7:0]          en_serv_q, en_serv_d;
    logic [7:0]          int_q, int_d;
    logic [PC_WIDTH-1:0] vec_q, vec_d;

    logic [7:0]          flanco;
    logic [7:0]          permitido;
    logic                bloqueo_acc;
    logic [7:0]          elegibles;
    logic [7:0]          cand_onehot;
    logic [2:0]          cand_idx;
    logic [PC_WIDTH-1:0] vec_cand;
    logic [7:0]          eoi_limpiar;
    logic [7:0]          limpiar;
    logic [7:0]          marcar;

    assign flanco = irq_i & ~irq_prev_q;

    // A level may only be presented if no level of equal or higher priority is in service.
    always_comb begin
        bloqueo_acc = 1'b0;
        permitido   = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bloqueo_acc  = bloqueo_acc | en_serv_q[i];
            permitido[i] = ~bloqueo_acc;
        end
    end

    assign elegibles   = pend_q & mask_q & permitido & {8{habilitar_i}};
    assign cand_onehot = elegibles & (~elegibles + 8'd1);

    always_comb begin
        cand_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (elegibles[i]) begin
                cand_idx = 3'(i);
            end
        end
    end

    assign vec_cand = VEC_BASE + PC_WIDTH'(int'(cand_idx) * VEC_STRIDE);

    // eoi retires the highest-priority level in service, using the pre-update value.
    assign eoi_limpiar = eoi_i ? (en_serv_q & (~en_serv_q + 8'd1)) : 8'd0;

    always_comb begin
        estado_d = estado_q;
        int_d    = int_q;
        vec_d    = vec_q;
        limpiar  = 8'd0;
        marcar   = 8'd0;
        case (estado_q)
            REPOSO: begin
                int_d = 8'd0;
                if (|elegibles) begin
                    int_d    = cand_onehot;
                    vec_d    = vec_cand;
                    estado_d = SOLICITUD;
                end
            end
            SOLICITUD: begin
                if (ack_i) begin
                    limpiar  = int_q;
                    marcar   = int_q;
                    int_d    = 8'd0;
                    estado_d = REPOSO;
                end else if (!habilitar_i) begin
                    int_d    = 8'd0;
                    estado_d = REPOSO;
                end
            end
            default: begin
                int_d    = 8'd0;
                estado_d = REPOSO;
            end
        endcase
    end

    // A fresh edge in the ack cycle re-arms the same level.
    assign pend_d    = (pend_q & ~limpiar) | flanco;
    assign en_serv_d = (en_serv_q & ~eoi_limpiar) | marcar;
    assign mask_d    = we_mask_i ? dato_mask_i : mask_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            estado_q   <= REPOSO;
            irq_prev_q <= 8'd0;
            pend_q     <= 8'd0;
            mask_q     <= 8'd0;
            en_serv_q  <= 8'd0;
            int_q      <= 8'd0;
            vec_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            irq_prev_q <= irq_i;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            en_serv_q  <= en_serv_d;
            int_q      <= int_d;
            vec_q      <= vec_d;
        end
    end

    assign interrupcion_o = int_q;
    assign vector_o       = vec_q;
    assign pendientes_o   = pend_q;
    assign en_servicio_o  = en_serv_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Scoreboard bench for controlador_interrupciones: expectations are queued with the
// stimulus and drained against the DUT outputs one cycle later.
module tb_controlador_interrupciones;

    localparam int SEL_INT  = 0;
    localparam int SEL_VEC  = 1;
    localparam int SEL_PEND = 2;
    localparam int SEL_SERV = 3;
    localparam int SEL_NPRE = 4;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] irq_i = 8'd0;
    logic       habilitar_i = 1'b1;
    logic       we_mask_i = 1'b0;
    logic [7:0] dato_mask_i = 8'd0;
    logic       ack_i = 1'b0;
    logic       eoi_i = 1'b0;
    logic [7:0] interrupcion_o;
    logic [9:0] vector_o;
    logic [7:0] pendientes_o;
    logic [7:0] en_servicio_o;

    typedef struct {
        string      tag;
        int         sel;
        logic [9:0] esperado;
    } esperado_t;

    esperado_t cola[$];
    int        n_total = 0;
    int        n_pass  = 0;
    int        n_present = 0;
    logic [7:0] int_prev = 8'd0;

    controlador_interrupciones #(
        .PC_WIDTH  (10),
        .VEC_BASE  (10'h3C0),
        .VEC_STRIDE(8)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .irq_i         (irq_i),
        .habilitar_i   (habilitar_i),
        .we_mask_i     (we_mask_i),
        .dato_mask_i   (dato_mask_i),
        .ack_i         (ack_i),
        .eoi_i         (eoi_i),
        .interrupcion_o(interrupcion_o),
        .vector_o      (vector_o),
        .pendientes_o  (pendientes_o),
        .en_servicio_o (en_servicio_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic verificar(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
        n_total++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    task automatic esperar(input string tag, input int sel, input logic [9:0] v);
        esperado_t e;
        e.tag = tag;
        e.sel = sel;
        e.esperado = v;
        cola.push_back(e);
    endtask

    function automatic logic [9:0] leer(input int sel);
        case (sel)
            SEL_INT:  return {2'b00, interrupcion_o};
            SEL_VEC:  return vector_o;
            SEL_PEND: return {2'b00, pendientes_o};
            SEL_SERV: return {2'b00, en_servicio_o};
            default:  return 10'(n_present);
        endcase
    endfunction

    task automatic revisar();
        esperado_t e;
        while (cola.size() > 0) begin
            e = cola.pop_front();
            verificar(e.tag, leer(e.sel), e.esperado);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
            if (interrupcion_o != 8'd0 && int_prev == 8'd0) n_present++;
            int_prev = interrupcion_o;
        end
    endtask

    task automatic pulso(input logic [7:0] v);
        irq_i = v;
        tick();
        irq_i = 8'd0;
    endtask

    initial begin
        tick(2);
        reset_i = 1'b0;
        esperar("rst_int", SEL_INT, 10'h000);
        esperar("rst_vec", SEL_VEC, 10'h000);
        esperar("rst_pend", SEL_PEND, 10'h000);
        esperar("rst_serv", SEL_SERV, 10'h000);
        revisar();

        // Masked request stays pending until the mask opens.
        pulso(8'h08);
        tick();
        esperar("masked_pend", SEL_PEND, 10'h008);
        esperar("masked_int", SEL_INT, 10'h000);
        revisar();
        we_mask_i = 1'b1; dato_mask_i = 8'hFF;
        tick();
        we_mask_i = 1'b0;
        esperar("mask_lat1_int", SEL_INT, 10'h000);
        revisar();
        tick();
        esperar("mask_lat2_int", SEL_INT, 10'h008);
        esperar("mask_lat2_vec", SEL_VEC, 10'h3D8);
        revisar();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        esperar("l3_ack_serv", SEL_SERV, 10'h008);
        revisar();
        eoi_i = 1'b1; tick(); eoi_i = 1'b0;
        esperar("l3_eoi_serv", SEL_SERV, 10'h000);
        revisar();

        // Simultaneous edges: lower index wins, level 5 blocked behind level 2.
        pulso(8'h24);
        tick();
        esperar("pri_int", SEL_INT, 10'h004);
        esperar("pri_vec", SEL_VEC, 10'h3D0);
        revisar();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        esperar("pri_ack_serv", SEL_SERV, 10'h004);
        esperar("pri_ack_pend", SEL_PEND, 10'h020);
        esperar("pri_ack_int", SEL_INT, 10'h000);
        revisar();
        tick(3);
        esperar("blocked_int", SEL_INT, 10'h000);
        revisar();

        // Nesting: level 0 preempts level 2; eoi unwinds lowest index first.
        pulso(8'h01);
        tick();
        esperar("nest_int", SEL_INT, 10'h001);
        esperar("nest_vec", SEL_VEC, 10'h3C0);
        revisar();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        esperar("nest_serv", SEL_SERV, 10'h005);
        revisar();
        eoi_i = 1'b1; tick();
        esperar("eoi1_serv", SEL_SERV, 10'h004);
        revisar();
        tick(); eoi_i = 1'b0;
        esperar("eoi2_serv", SEL_SERV, 10'h000);
        esperar("eoi2_int", SEL_INT, 10'h000);
        revisar();
        tick();
        esperar("l5_int", SEL_INT, 10'h020);
        esperar("l5_vec", SEL_VEC, 10'h3E8);
        revisar();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        eoi_i = 1'b1; tick(); eoi_i = 1'b0;
        esperar("l5_clean", SEL_SERV, 10'h000);
        revisar();

        // Withdrawal on habilitar low, then re-presentation.
        pulso(8'h10);
        tick();
        esperar("wd_int", SEL_INT, 10'h010);
        esperar("wd_vec", SEL_VEC, 10'h3E0);
        revisar();
        habilitar_i = 1'b0;
        tick();
        esperar("wd_off_int", SEL_INT, 10'h000);
        esperar("wd_off_vec", SEL_VEC, 10'h3E0);
        esperar("wd_off_pend", SEL_PEND, 10'h010);
        revisar();
        tick(2);
        esperar("wd_still_int", SEL_INT, 10'h000);
        revisar();
        habilitar_i = 1'b1;
        tick();
        esperar("wd_back_int", SEL_INT, 10'h010);
        revisar();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        eoi_i = 1'b1; tick(); eoi_i = 1'b0;

        // New edge during ack keeps the level pending; ack+eoi is clear-old, set-new.
        pulso(8'h02);
        tick();
        esperar("re_int", SEL_INT, 10'h002);
        revisar();
        ack_i = 1'b1; irq_i = 8'h02;
        tick();
        ack_i = 1'b0; irq_i = 8'h00;
        esperar("re_serv", SEL_SERV, 10'h002);
        esperar("re_pend", SEL_PEND, 10'h002);
        revisar();
        pulso(8'h01);
        tick();
        esperar("ae_int", SEL_INT, 10'h001);
        revisar();
        ack_i = 1'b1; eoi_i = 1'b1;
        tick();
        ack_i = 1'b0; eoi_i = 1'b0;
        esperar("ae_serv", SEL_SERV, 10'h001);
        esperar("ae_pend", SEL_PEND, 10'h002);
        revisar();
        eoi_i = 1'b1; tick(); eoi_i = 1'b0;
        tick();
        esperar("l1_again_int", SEL_INT, 10'h002);
        revisar();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        eoi_i = 1'b1; tick(); eoi_i = 1'b0;
        esperar("l1_clean", SEL_SERV, 10'h000);
        revisar();

        // Level held high gives a single presentation.
        n_present = 0;
        irq_i = 8'h80;
        tick(2);
        esperar("hold_int", SEL_INT, 10'h080);
        esperar("hold_vec", SEL_VEC, 10'h3F8);
        revisar();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        eoi_i = 1'b1; tick(); eoi_i = 1'b0;
        tick(6);
        irq_i = 8'h00;
        esperar("hold_npres", SEL_NPRE, 10'd1);
        esperar("hold_pend", SEL_PEND, 10'h000);
        revisar();

        // Reset during SOLICITUD, with a concurrent ack, clears everything incl. the mask.
        pulso(8'h08);
        tick();
        esperar("pre_rst_int", SEL_INT, 10'h008);
        revisar();
        reset_i = 1'b1; ack_i = 1'b1;
        tick();
        reset_i = 1'b0; ack_i = 1'b0;
        esperar("mid_rst_int", SEL_INT, 10'h000);
        esperar("mid_rst_vec", SEL_VEC, 10'h000);
        esperar("mid_rst_pend", SEL_PEND, 10'h000);
        esperar("mid_rst_serv", SEL_SERV, 10'h000);
        revisar();
        pulso(8'h01);
        tick(2);
        esperar("post_rst_mask_int", SEL_INT, 10'h000);
        esperar("post_rst_mask_pend", SEL_PEND, 10'h001);
        revisar();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
